// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types for the data-memory load/store sequencer.
//   mem_size_t   : access size encoding used on req_size (3 is illegal)
//   dmem_state_t : controller FSM states
//   misaligned() : alignment / legality check for a request
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LRESP,
        MERGE,
        WRITE,
        ERR
    } dmem_state_t;

    // True when the access cannot be performed: half on an odd address,
    // word off a word boundary, or the unused size encoding 3.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational little-endian lane logic for the data-memory path.
//   word        in  32  full memory word
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size (mem_size_t encoding)
//   is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//   store_data  in  32  right-justified store data
//   load_data   out 32  addressed lane, extended to 32 bits
//   merged_word out 32  word with the addressed lane(s) replaced by store data
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case statements leaves it unassigned (latch).
        load_data = '0;
        lane_b    = word[{offset, 3'b000} +: 8];
        lane_h    = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SIZE_B:  load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SIZE_H:  load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            SIZE_W:  load_data = word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = word;
        case (size)
            SIZE_B:  merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
            SIZE_H:  merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            SIZE_W:  merged_word = store_data;
            default: merged_word = word;
        endcase
    end

endmodule

// File: rtl/dmem_controller.sv
// -----------------------------------------------------------------------------
// dmem_controller
// Load/store sequencer between the core memory stage and a word-wide data
// memory with a one-cycle registered read. Sub-word stores are done as
// read-modify-write; misaligned or illegal-size requests complete with an
// error and never touch memory.
//   clk, reset (sync, active high)
//   req_valid/req_ready handshake, req_write, req_size, req_unsigned,
//   req_addr, req_wdata                        : request from the core
//   resp_valid (1-cycle pulse), resp_rdata, resp_error : completion
//   mem_read_addr, mem_read_data              : memory read port
//   mem_write_addr, mem_write_data, mem_write_enable : memory write port
// -----------------------------------------------------------------------------
module dmem_controller
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable
);

    dmem_state_t       state;
    dmem_state_t       state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;

    logic              accept;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;

    // Ready is held low while reset is asserted, even if the state is IDLE.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------ capture registers
    always_ff @(posedge clk) begin
        // NOTE: capture registers are reset too, because the memory-side
        // address and data outputs are driven straight from them and must
        // read 0 out of reset.
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_next = ERR;
                    end else if (req_write && (req_size == SIZE_W)) begin
                        state_next = WRITE;
                    end else begin
                        // Loads and sub-word stores both need the word first.
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = write_q ? MERGE : LRESP;
            LRESP:   state_next = IDLE;
            MERGE:   state_next = IDLE;
            WRITE:   state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- lane logic
    dmem_lane_align u_lane_align (
        .word        (mem_read_data),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // ---------------------------------------------------------------- outputs
    assign mem_read_addr  = addr_q;
    assign mem_write_addr = addr_q;

    // Completion-side outputs are suppressed in a reset cycle so a pending
    // MERGE/WRITE can never strobe memory while reset is high.
    always_comb begin
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        resp_rdata       = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        if (!reset) begin
            case (state)
                LRESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = load_data;
                end
                MERGE: begin
                    resp_valid       = 1'b1;
                    mem_write_enable = 1'b1;
                    mem_write_data   = merged_word;
                end
                WRITE: begin
                    resp_valid       = 1'b1;
                    mem_write_enable = 1'b1;
                    mem_write_data   = wdata_q;
                end
                ERR: begin
                    resp_valid = 1'b1;
                    resp_error = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
